// File: rtl/inv_keyexp_iter.sv
// AES S-box: multiplicative inverse in GF(2^8) followed by the FIPS-197 affine map.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Substitution of one byte
    always_comb begin
        o_out = affine(gf_inv(i_in));
    end

endmodule

// Inverse AES key schedule: regenerates w[W-1..0] one word per cycle from the last NK words.
// Latency: round NR key valid 4 cycles after start, then one round key every 4 cycles.
// Backpressure: o_valid && !i_ready freezes window, counter and assembly; outputs hold.
module inv_keyexp_iter #(
    parameter int WORD = 32,
    parameter int NB   = 4,
    parameter int NK   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [NK*WORD-1:0]   i_key,
    output logic                 o_busy,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [127:0]         o_rkey,
    output logic [3:0]           o_round,
    output logic                 o_done
);

    localparam int NR = NK + 6;
    localparam int W  = NB * (NR + 1);
    localparam logic [5:0] CNT_INIT = 6'(W - 1);
    localparam logic [5:0] NK_W     = 6'(NK);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   round_q, round_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;
    logic [31:0]  win_q [NK];
    logic [127:0] asm_q, asm_d;

    logic         advance;
    logic [31:0]  x, sub_in, sub_out, f_val, g;
    logic [3:0]   j_mod, j_div;
    logic         rot_step, sub_step;
    logic [7:0]   rcon;

    assign advance = (state_q == S_RUN) && !(valid_q && !i_ready);

    // Select the schedule step for index cnt and the S-box input word
    always_comb begin
        x        = win_q[NK-2];
        j_mod    = 4'(int'(cnt_q) % NK);
        j_div    = 4'(int'(cnt_q) / NK);
        rot_step = (j_mod == 4'd0);
        sub_step = (NK == 8) && (j_mod == 4'd4);
        sub_in   = rot_step ? {x[23:0], x[31:24]} : x;
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        sbox u_sbox (
            .i_in  (sub_in[8*b +: 8]),
            .o_out (sub_out[8*b +: 8])
        );
    end

    // Undo one forward step: w[cnt-NK] = w[cnt] ^ f(w[cnt-1]); drop the word into its asm slot
    always_comb begin
        case (j_div)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        if (rot_step)      f_val = sub_out ^ {rcon, 24'h000000};
        else if (sub_step) f_val = sub_out;
        else               f_val = x;
        // Below index NK there is nothing left to regenerate
        g = (cnt_q < NK_W) ? 32'h0 : (win_q[NK-1] ^ f_val);
        asm_d = asm_q;
        case (cnt_q[1:0])
            2'd0:    asm_d[127:96] = win_q[NK-1];
            2'd1:    asm_d[95:64]  = win_q[NK-1];
            2'd2:    asm_d[63:32]  = win_q[NK-1];
            default: asm_d[31:0]   = win_q[NK-1];
        endcase
    end

    // Window and assembly registers: no reset, only meaningful while running
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && i_start) begin
            for (int k = 0; k < NK; k++) begin
                win_q[k] <= i_key[(NK-1-k)*WORD +: WORD];
            end
        end else if (advance) begin
            win_q[0] <= g;
            for (int k = 1; k < NK; k++) begin
                win_q[k] <= win_q[k-1];
            end
            asm_q <= asm_d;
        end
    end

    // Control next state: load, advance/emit, drain the round-0 key
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rkey_d  = rkey_q;
        round_d = round_q;
        valid_d = valid_q && !i_ready;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_INIT;
                end
            end
            S_RUN: begin
                if (advance) begin
                    if (cnt_q[1:0] == 2'd0) begin
                        rkey_d  = asm_d;
                        round_d = cnt_q[5:2];
                        valid_d = 1'b1;
                    end
                    if (cnt_q == 6'd0) state_d = S_DRAIN;
                    else               cnt_d   = cnt_q - 6'd1;
                end
            end
            S_DRAIN: begin
                if (valid_q && i_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            rkey_q  <= 128'h0;
            round_q <= 4'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rkey_q  <= rkey_d;
            round_q <= round_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign o_busy  = (state_q != S_IDLE);
    assign o_valid = valid_q;
    assign o_rkey  = rkey_q;
    assign o_round = round_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_inv_keyexp_iter.sv
// Bench for the inverse key schedule: three instances (NK=4,6,8) against a forward-expansion model.
// Expected round keys are queued at start; a negedge monitor compares every presented key.
// Ready is either held high or randomized with a forced 8-cycle stall on round 5.
module tb_inv_keyexp_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start [3];
    logic         rdy   [3];
    logic         vld   [3];
    logic         busy  [3];
    logic         done  [3];
    logic [127:0] rk    [3];
    logic [3:0]   rd    [3];
    logic [127:0] key128;
    logic [191:0] key192;
    logic [255:0] key256;

    inv_keyexp_iter #(.WORD(32), .NB(4), .NK(4)) u_dut128 (
        .clk(clk), .rst(rst), .i_start(start[0]), .i_key(key128), .o_busy(busy[0]),
        .o_valid(vld[0]), .i_ready(rdy[0]), .o_rkey(rk[0]), .o_round(rd[0]), .o_done(done[0]));
    inv_keyexp_iter #(.WORD(32), .NB(4), .NK(6)) u_dut192 (
        .clk(clk), .rst(rst), .i_start(start[1]), .i_key(key192), .o_busy(busy[1]),
        .o_valid(vld[1]), .i_ready(rdy[1]), .o_rkey(rk[1]), .o_round(rd[1]), .o_done(done[1]));
    inv_keyexp_iter #(.WORD(32), .NB(4), .NK(8)) u_dut256 (
        .clk(clk), .rst(rst), .i_start(start[2]), .i_key(key256), .o_busy(busy[2]),
        .o_valid(vld[2]), .i_ready(rdy[2]), .o_rkey(rk[2]), .o_round(rd[2]), .o_done(done[2]));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [131:0] exp_mem [3][16];
    int           head [3] = '{0, 0, 0};
    int           tail [3] = '{0, 0, 0};
    logic [127:0] got  [3][16];
    int           acc_cnt  [3] = '{0, 0, 0};
    int           done_cnt [3] = '{0, 0, 0};
    int           acc_cyc  [16];
    int           rmode [3] = '{0, 0, 0};
    int           hold  [3] = '{0, 0, 0};

    // Reference S-box table, row = high nibble
    localparam logic [127:0] SBR [16] = '{
        128'h637c777b_f26b6fc5_3001672b_fed7ab76, 128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115, 128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84, 128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8, 128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973, 128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479, 128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a, 128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df, 128'h8ca1890d_bfe64268_41992d0f_b054bb16};

    function automatic logic [7:0] sbm(input logic [7:0] v);
        logic [127:0] row;
        row = SBR[v[7:4]];
        row = row << (8 * int'(v[3:0]));
        return row[127:120];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbm(t[31:24]), sbm(t[23:16]), sbm(t[15:8]), sbm(t[7:0])};
    endfunction

    logic [31:0] mk [8];
    logic [31:0] mw [60];

    // Forward FIPS-197 key expansion of mk into mw
    task automatic model_expand(input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) mw[i] = mk[i];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk == 8 && i % 8 == 4) begin
                t = subw(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    // Expand mk, queue expected round keys NR..0 for instance d, and set its i_key
    task automatic load(input int d, input int nk);
        int nw;
        model_expand(nk);
        nw = 4 * (nk + 7);
        head[d] = 0;
        tail[d] = 0;
        acc_cnt[d] = 0;
        done_cnt[d] = 0;
        hold[d] = 0;
        for (int r = 0; r < 16; r++) got[d][r] = '0;
        for (int r = nk + 6; r >= 0; r--) begin
            exp_mem[d][tail[d] % 16] = {4'(r), mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
            tail[d]++;
        end
        for (int k = 0; k < nk; k++) begin
            case (d)
                0:       key128[(nk-1-k)*32 +: 32] = mw[nw-nk+k];
                1:       key192[(nk-1-k)*32 +: 32] = mw[nw-nk+k];
                default: key256[(nk-1-k)*32 +: 32] = mw[nw-nk+k];
            endcase
        end
    endtask

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int d, input int budget);
        int k;
        k = 0;
        while (done_cnt[d] == 0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (done_cnt[d] == 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_done dut%0d: no o_done within %0d cycles", d, budget);
        end
    endtask

    // Monitor: compare every presented key against the queue head, pop on handshake
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int d = 0; d < 3; d++) begin
                    if (done[d]) done_cnt[d]++;
                    if (vld[d]) begin
                        if (head[d] == tail[d]) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_key dut%0d: round %0d with empty queue", d, rd[d]);
                        end else begin
                            check($sformatf("rkey_dut%0d", d), {rd[d], rk[d]}, exp_mem[d][head[d] % 16]);
                            if (rdy[d]) begin
                                got[d][rd[d]] = rk[d];
                                if (d == 0 && acc_cnt[0] < 16) acc_cyc[acc_cnt[0]] = cyc;
                                acc_cnt[d]++;
                                head[d]++;
                            end
                        end
                    end
                end
            end
        end
    end

    // Ready driver: constant high, or random with a forced 8-cycle stall on round 5
    initial begin
        for (int d = 0; d < 3; d++) rdy[d] = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (rmode[d] == 0) rdy[d] = 1'b1;
                else if (vld[d] && rd[d] == 4'd5 && hold[d] < 8) begin
                    rdy[d] = 1'b0;
                    hold[d]++;
                end else rdy[d] = 1'($urandom_range(0, 1));
            end
        end
    end

    logic [191:0] key192_saved;
    int t0;

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 3; d++) start[d] = 1'b0;
        key128 = '0;
        key192 = '0;
        key256 = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_outs_dut%0d", d),
                  {busy[d], vld[d], done[d], rd[d], rk[d]}, '0);
        end
        rst = 1'b1;

        // Phase 1: FIPS AES-128, random AES-192, FIPS AES-256, ready held high
        mk[0] = 32'h2b7e1516; mk[1] = 32'h28aed2a6; mk[2] = 32'habf71588; mk[3] = 32'h09cf4f3c;
        load(0, 4);
        for (int i = 0; i < 6; i++) mk[i] = $urandom();
        load(1, 6);
        key192_saved = key192;
        mk[0] = 32'h603deb10; mk[1] = 32'h15ca71be; mk[2] = 32'h2b73aef0; mk[3] = 32'h857d7781;
        mk[4] = 32'h1f352c07; mk[5] = 32'h3b6108d7; mk[6] = 32'h2d9810a3; mk[7] = 32'h0914dff4;
        load(2, 8);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) start[d] = 1'b1;
        t0 = cyc + 1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) start[d] = 1'b0;
        check("busy_after_start", {busy[0], busy[1], busy[2]}, 3'b111);
        for (int d = 0; d < 3; d++) wait_done(d, 200);
        repeat (3) @(posedge clk);
        #1;
        check("count128", acc_cnt[0], 11);
        check("count192", acc_cnt[1], 13);
        check("count256", acc_cnt[2], 15);
        check("done_once", {done_cnt[0], done_cnt[1], done_cnt[2]}, {32'd1, 32'd1, 32'd1});
        check("busy_low_end", {busy[0], busy[1], busy[2]}, 3'b000);
        for (int k = 0; k < 11; k++) check($sformatf("timing_k%0d", k), acc_cyc[k], t0 + 4 + 4 * k);
        check("r10_eq_key", got[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("r9_128", got[0][9], 128'hac7766f319fadc2128d12941575c006e);
        check("r0_128", got[0][0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("r1_256", got[2][1], 128'h1f352c073b6108d72d9810a30914dff4);
        check("r0_256", got[2][0], 128'h603deb1015ca71be2b73aef0857d7781);
        check("r12_192_low_key", got[1][12], key192_saved[127:0]);

        // Phase 2: random ready with a long stall; FIPS-128 again plus fresh random keys
        mk[0] = 32'h2b7e1516; mk[1] = 32'h28aed2a6; mk[2] = 32'habf71588; mk[3] = 32'h09cf4f3c;
        load(0, 4);
        for (int i = 0; i < 6; i++) mk[i] = $urandom();
        load(1, 6);
        for (int i = 0; i < 8; i++) mk[i] = $urandom();
        load(2, 8);
        for (int d = 0; d < 3; d++) rmode[d] = 1;
        for (int d = 0; d < 3; d++) start[d] = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) start[d] = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        key128 = {$urandom(), $urandom(), $urandom(), $urandom()};
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        for (int d = 0; d < 3; d++) wait_done(d, 1500);
        repeat (3) @(posedge clk);
        #1;
        check("bp_count128", acc_cnt[0], 11);
        check("bp_count192", acc_cnt[1], 13);
        check("bp_count256", acc_cnt[2], 15);
        check("bp_done_once", {done_cnt[0], done_cnt[1], done_cnt[2]}, {32'd1, 32'd1, 32'd1});
        check("bp_stall_seen", hold[0], 8);
        check("bp_idle_after", busy[0], 1'b0);

        // Phase 3: reset while round 3 is presented, then a fresh run
        for (int d = 0; d < 3; d++) rmode[d] = 0;
        for (int i = 0; i < 4; i++) mk[i] = $urandom();
        load(0, 4);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        begin
            int k;
            k = 0;
            while (!(vld[0] && rd[0] == 4'd3) && k < 100) begin
                @(posedge clk);
                #1;
                k++;
            end
            check("reached_r3", {vld[0], rd[0]}, {1'b1, 4'd3});
        end
        rst = 1'b0;
        head[0] = tail[0];
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("rst_mid_valid", vld[0], 1'b0);
        check("rst_mid_busy", busy[0], 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_no_done", done_cnt[0], 0);
        for (int i = 0; i < 4; i++) mk[i] = $urandom();
        load(0, 4);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        wait_done(0, 200);
        repeat (2) @(posedge clk);
        #1;
        check("fresh_count", acc_cnt[0], 11);
        check("fresh_done", done_cnt[0], 1);
        check("fresh_queue_empty", tail[0] - head[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inv_keyexp_iter.md
Name: inv_keyexp_iter

Overview:
- Iterative inverse AES key schedule for the decryption datapath.
- Loads the final Nk words of the expanded key and regenerates earlier words one word per cycle, in descending index order.
- Assembles the words into 128-bit round keys and emits them in decryption order (round NR down to round 0) over a valid/ready handshake.
- Reuses the existing sbox module: four instances, shared across all rounds.

Parameters:
- WORD, 32, word width; only 32 is supported.
- NB, 4, words per round key; only 4 is supported.
- NK, 4, key length in words; 4, 6 or 8. NR = NK+6. Total words W = NB*(NR+1), i.e. 44, 52 or 60.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous, active-low reset.
- i_start, input, 1, load i_key and begin. Ignored unless idle.
- i_key, input, NK*WORD, words w[W-NK..W-1]. w[W-1] is in bits [31:0]; w[W-NK] is in the MSB word.
- o_busy, output, 1, high from load until the round-0 key is accepted.
- o_valid, output, 1, o_rkey/o_round are valid.
- i_ready, input, 1, consumer accepts when o_valid && i_ready.
- o_rkey, output, 128, round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}; w[4r] is in [127:96].
- o_round, output, 4, round index r of o_rkey.
- o_done, output, 1, one-cycle pulse on the cycle after the round-0 key is accepted.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; o_busy=0, o_valid=0, o_done=0, o_rkey=0, o_round=0. The window and assembly registers are don't-care. Reset mid-run aborts immediately; no further outputs.
- States:
  - IDLE: i_start=1 loads window win[k]=w[W-NK+k] for k=0..NK-1 and sets cnt=W-1 (index of win[NK-1]). Next state RUN, o_busy=1.
  - RUN: advances on every cycle where stall = o_valid && !i_ready is 0.
  - Each advance:
    - asm slot (cnt mod 4) <= win[NK-1]; slot 3 is [31:0], slot 0 is [127:96].
    - Window shifts up: win[k+1] <= win[k]; win[0] <= g.
    - g = w[cnt-NK] = win[NK-1] ^ f(win[NK-2]), with j = cnt:
      - j mod NK == 0: f(x) = SubWord(RotWord(x)) ^ Rcon[j/NK]. Rcon = 01,02,04,08,10,20,40,80,1b,36 in the MSB byte.
      - NK == 8 and j mod 8 == 4: f(x) = SubWord(x).
      - otherwise: f(x) = x.
    - When cnt < NK, g is don't-care (never emitted); 0 is written.
    - If cnt mod 4 == 0: o_rkey <= completed asm (including this word), o_round <= cnt/4, o_valid <= 1.
    - If cnt == 0: go to DRAIN. Otherwise cnt <= cnt-1.
  - Stall: window, cnt and asm hold; o_rkey/o_round stay stable while o_valid=1. o_valid clears on handshake unless a new key is loaded in the same cycle.
  - DRAIN: wait for the round-0 handshake, then go to IDLE, o_busy=0, o_done=1 for one cycle.
- Timing: with i_ready held high, after i_start at edge T, o_valid first goes high after edge T+4 (round NR). Each subsequent round follows 4 cycles later. Round 0 appears after edge T+W/4*4 = T+W.
- i_start while o_busy=1 is ignored. i_start in the same cycle as o_done is accepted (IDLE).
- RotWord is a 1-byte left rotate. SubWord applies sbox per byte. All XORs are 32-bit, with no width growth.

Test Plan:
- AES-128 FIPS-197: i_key = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, i_ready=1.
  - r=10 key equals i_key.
  - r=9 = ac7766f3 19fadc21 28d12941 575c006e.
  - r=0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - Keys arrive 4 cycles apart; 11 keys total; o_done pulses once.
- AES-256 (NK=8): load w[52..59] from the reference model for FIPS key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4.
  - 15 round keys match the model.
  - r=0 = 603deb10 15ca71be 2b73aef0 857d7781; r=1 = 1f352c07 3b6108d7 2d9810a3 0914dff4.
- AES-192 (NK=6): random keys versus the model.
  - 13 rounds match.
  - The first emitted key r=12 equals the low 4 words of i_key.
- Backpressure: random i_ready, including an 8-cycle hold low at r=5.
  - o_rkey/o_round stay stable while stalled.
  - The sequence is identical to the no-stall run with no drop or duplicate.
- i_start pulsed mid-run is ignored. rst=0 asserted at r=3 forces o_valid=0 and o_busy=0 next cycle. A fresh start then completes correctly.
